// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: fixed-latency multiply, 1-bit/cycle restoring divide.
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish in one cycle.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [2:0]       r_f3;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_div, r_quo, r_rem;
  logic             r_neg_q, r_neg_r, r_is_rem;

  logic             w_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_div0, w_ovf, w_early, w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx, w_quo_nx, w_div_res;

  // Operand extension chosen by funct3; the product is taken modulo 2^(2*WIDTH).
  function automatic logic [WIDTH-1:0] mul_result(input logic [2:0] f3,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ea, eb, prod;
    ea   = {{WIDTH{((f3[1:0] == 2'b01) || (f3[1:0] == 2'b10)) & a[WIDTH-1]}}, a};
    eb   = {{WIDTH{(f3[1:0] == 2'b01) & b[WIDTH-1]}}, b};
    prod = ea * eb;
    return (f3[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Operand decode for an op about to be accepted
  assign w_sgn   = ~funct3_i[0];
  assign w_a_neg = w_sgn & a_i[WIDTH-1];
  assign w_b_neg = w_sgn & b_i[WIDTH-1];
  assign w_a_mag = neg_if(w_a_neg, a_i);
  assign w_b_mag = neg_if(w_b_neg, b_i);
  assign w_div0  = (b_i == '0);
  assign w_ovf   = w_sgn && (a_i == MOST_NEG) && (b_i == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  assign w_special = w_div0 | w_ovf | w_early;

  always_comb begin
    w_spec_res = '0;
    if (w_div0)      w_spec_res = funct3_i[1] ? a_i : '1;
    else if (w_ovf)  w_spec_res = funct3_i[1] ? '0  : a_i;
    else             w_spec_res = funct3_i[1] ? a_i : '0;
  end

  // One restoring-divide iteration on the magnitudes
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_div};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
  assign w_div_res = r_is_rem ? neg_if(r_neg_r, w_rem_nx) : neg_if(r_neg_q, w_quo_nx);

  assign stall_o  = ((r_state == S_IDLE) && start_i && !flush_i) ||
                    (r_state == S_MUL) || (r_state == S_DIV);
  assign done_o   = r_done;
  assign result_o = r_result;

  // Control: state, iteration counter, completion pulse and result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_cnt <= '0;
              if (!funct3_i[2]) begin
                if (MUL_LATENCY == 1) begin
                  r_state  <= S_DONE;
                  r_done   <= 1'b1;
                  r_result <= mul_result(funct3_i, a_i, b_i);
                end else begin
                  r_state <= S_MUL;
                end
              end else if (w_special) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_result <= w_spec_res;
              end else begin
                r_state <= S_DIV;
              end
            end
          end
          S_MUL: begin
            if (r_cnt == MUL_LAST) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= mul_result(r_f3, r_a, r_b);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_DIV: begin
            if (r_cnt == DIV_LAST) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_div_res;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Datapath: operand capture at acceptance, then divider iterations
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && start_i) begin
      r_f3     <= funct3_i;
      r_a      <= a_i;
      r_b      <= b_i;
      r_div    <= w_b_mag;
      r_quo    <= w_a_mag;
      r_rem    <= '0;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_is_rem <= funct3_i[1];
    end else if (r_state == S_DIV) begin
      r_quo <= w_quo_nx;
      r_rem <= w_rem_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a scoreboard of expected results and latencies.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int ML = 3;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int DL = W + 1;

  logic         clk = 1'b0;
  logic         rst, start_i, flush_i;
  logic [2:0]   funct3_i;
  logic [W-1:0] a_i, b_i;
  logic         stall_o, done_o;
  logic [W-1:0] result_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    string        tag;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    funct3_i = f3; a_i = a; b_i = b; start_i = 1'b1;
    e.res = exp; e.lat = lat; e.tag = tag;
    sb.push_back(e);
    #1;
    check({tag, " stall@N"}, W'(stall_o), W'(1));
    check({tag, " done@N"},  W'(done_o),  W'(0));
  endtask

  task automatic wait_done(input bit hold);
    exp_t e;
    int   k;
    e = sb.pop_front();
    k = 0;
    while (k < e.lat + 3) begin
      @(negedge clk);
      k++;
      a_i = $urandom();
      b_i = $urandom();
      if (done_o) break;
      check({e.tag, " stall_busy"}, W'(stall_o), W'(1));
    end
    check({e.tag, " latency"}, W'(k), W'(e.lat));
    check({e.tag, " result"},  result_o, e.res);
    check({e.tag, " stall@done"}, W'(stall_o), W'(0));
    last_res = e.res;
    if (!hold) start_i = 1'b0;
  endtask

  initial begin
    exp_t         tmp;
    logic [W-1:0] ra, rb, rexp;
    logic [63:0]  prod;
    logic [2:0]   rf;
    int           rlat;

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = 3'b000; a_i = '0; b_i = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    check("reset done",   W'(done_o),  W'(0));
    check("reset result", result_o,    W'(0));
    check("reset stall",  W'(stall_o), W'(0));
    rst = 1'b0;

    drive_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML);          wait_done(0);
    drive_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML); wait_done(0);
    drive_op("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML); wait_done(0);
    drive_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, ML); wait_done(0);
    drive_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML); wait_done(0);
    drive_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, DL);                       wait_done(0);
    drive_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, DL);                        wait_done(0);
    drive_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DL);       wait_done(0);
    drive_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DL);       wait_done(0);
    drive_op("rem_negb", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, DL);              wait_done(0);
    drive_op("div_nn", 3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, DL);        wait_done(0);
    drive_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);                   wait_done(0);
    drive_op("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);                           wait_done(0);
    drive_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); wait_done(0);
    drive_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);        wait_done(0);
    drive_op("divu_small", 3'b101, 32'd3, 32'd10, 32'd0, EARLY ? 1 : DL);       wait_done(0);
    drive_op("remu_small", 3'b111, 32'd3, 32'd10, 32'd3, EARLY ? 1 : DL);       wait_done(0);
    drive_op("rem_small_neg", 3'b110, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EARLY ? 1 : DL);
    wait_done(0);

    // Flush a DIVU in cycle N+10
    drive_op("flush_divu", 3'b101, 32'd1000, 32'd3, 32'd333, DL);
    tmp = sb.pop_back();
    repeat (10) @(negedge clk);
    check("flush pre stall", W'(stall_o), W'(1));
    flush_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush stall N+11", W'(stall_o), W'(0));
    check("flush done N+11",  W'(done_o),  W'(0));
    check("flush result",     result_o,    last_res);
    repeat (3) begin
      @(negedge clk);
      check("flush no done", W'(done_o), W'(0));
    end
    drive_op("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42, ML); wait_done(0);

    // Flush wins over start in IDLE
    @(negedge clk);
    funct3_i = 3'b000; a_i = 32'd2; b_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
    #1 check("flush_prio stall", W'(stall_o), W'(0));
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1 check("flush_prio not accepted", W'(stall_o), W'(0));
    check("flush_prio done", W'(done_o), W'(0));

    // Back-to-back: start held through DONE, next op accepted in DONE+1
    drive_op("b2b_mul", 3'b000, 32'd11, 32'd13, 32'd143, ML); wait_done(1);
    drive_op("b2b_divu", 3'b101, 32'd143, 32'd11, 32'd13, DL); wait_done(0);

    // Reset mid-operation
    drive_op("rst_mid", 3'b000, 32'd9, 32'd9, 32'd81, ML);
    tmp = sb.pop_back();
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check("rst_mid done",   W'(done_o),  W'(0));
    check("rst_mid stall",  W'(stall_o), W'(0));
    check("rst_mid result", result_o,    W'(0));
    rst = 1'b0;
    last_res = '0;

    // Randomised unsigned ops against a behavioural model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom();
      rb = (i == 0) ? '0 : ($urandom() >> $urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       rf = 3'b000;
        1:       rf = 3'b011;
        2:       rf = 3'b101;
        default: rf = 3'b111;
      endcase
      prod = {32'b0, ra} * {32'b0, rb};
      rlat = ML;
      case (rf)
        3'b000:  rexp = prod[31:0];
        3'b011:  rexp = prod[63:32];
        3'b101:  rexp = (rb == '0) ? '1 : ra / rb;
        default: rexp = (rb == '0) ? ra : ra % rb;
      endcase
      if (rf[2]) rlat = ((rb == '0) || (EARLY && (ra < rb))) ? 1 : DL;
      drive_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, rexp, rlat);
      wait_done(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
